gpio_bus_arbiter: RTL and testbench

- Round-robin arbiter that shares one native valid/ready peripheral bus slave between NUM_MASTERS requesters.
- Typical requesters: the CPU plus a pattern/DMA engine; typical slave: the GPIO register block.
- Sits between the requesters' bus ports and the slave's valid/ready/wstrb/addr/wdata/rdata port.
- Inserts the turnaround cycle that slaves with a registered ready (ready <= valid) require.

---
 rtl/gpio_bus_arbiter.sv | 155 +++++++++++++++
 tb/tb_gpio_bus_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_bus_arbiter.sv
// Round-robin arbiter sharing one valid/ready peripheral slave between masters.
// Define ARB_TIMEOUT_EN to add a BUSY watchdog and the timeout output.
//
// Ports:
//   clk, resetn          clock, async active-low reset
//   m_valid/m_ready      per-master request / completion pulse
//   m_wstrb/addr/wdata   packed per-master payload (master i at slice i)
//   m_rdata              slave read data broadcast to all masters
//   s_valid/s_ready      slave request / completion
//   s_wstrb/addr/wdata   granted master's payload, zero when not BUSY
//   s_rdata              slave read data
//   grant                one-hot current owner, zero when idle
//   timeout              (ARB_TIMEOUT_EN only) forced-completion pulse

module gpio_bus_arbiter #(
  parameter int          NUM_MASTERS    = 2,
  parameter int          TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_RDATA      = 32'hFFFF_FFFF
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NUM_MASTERS-1:0]    m_valid,
  output logic [NUM_MASTERS-1:0]    m_ready,
  input  logic [4*NUM_MASTERS-1:0]  m_wstrb,
  input  logic [32*NUM_MASTERS-1:0] m_addr,
  input  logic [32*NUM_MASTERS-1:0] m_wdata,
  output logic [31:0]               m_rdata,
  output logic                      s_valid,
  input  logic                      s_ready,
  output logic [3:0]                s_wstrb,
  output logic [31:0]               s_addr,
  output logic [31:0]               s_wdata,
  input  logic [31:0]               s_rdata,
`ifdef ARB_TIMEOUT_EN
  output logic                      timeout,
`endif
  output logic [NUM_MASTERS-1:0]    grant
);

  localparam int IDXW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RELEASE
  } state_e;

  state_e                 state_q;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [IDXW-1:0]        idx_q;
  logic [IDXW-1:0]        last_q;
  logic                   s_valid_q;

  logic                   busy;
  logic                   done;
  logic                   pick_found;
  logic [IDXW-1:0]        pick_idx;
  logic [IDXW-1:0]        cand;
  logic [NUM_MASTERS-1:0] grant_d;

  assign busy = (state_q == BUSY);

  // Scan last+1, last+2, ... with wrap; the first live request wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = IDXW'((int'(last_q) + k) % NUM_MASTERS);
      if (!pick_found && m_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign grant_d = NUM_MASTERS'(1) << pick_idx;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] cnt_q;
  logic          to_hit;

  assign to_hit  = busy && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  // A real completion in the same cycle beats the watchdog.
  assign timeout = to_hit && !s_ready;
  assign done    = s_ready || to_hit;
  assign m_rdata = timeout ? ERR_RDATA : s_rdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else if (!busy) begin
      cnt_q <= '0;
    end else if (!done) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg = ^{ERR_RDATA, TIMEOUT_CYCLES[0]};
  assign done       = s_ready;
  assign m_rdata    = s_rdata;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      idx_q     <= '0;
      last_q    <= IDXW'(NUM_MASTERS - 1);
      s_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, RELEASE: begin
          if (pick_found) begin
            state_q   <= BUSY;
            grant_q   <= grant_d;
            idx_q     <= pick_idx;
            s_valid_q <= 1'b1;
          end else begin
            state_q   <= IDLE;
            grant_q   <= '0;
            s_valid_q <= 1'b0;
          end
        end
        BUSY: begin
          if (done) begin
            state_q   <= RELEASE;
            last_q    <= idx_q;
            grant_q   <= '0;
            s_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          grant_q   <= '0;
          s_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign grant   = grant_q;
  assign s_valid = s_valid_q;
  assign m_ready = (busy && done) ? grant_q : '0;

  // Zero payload outside BUSY so strobe-decoding slaves never see a write.
  assign s_wstrb = busy ? m_wstrb[{idx_q, 2'b00} +: 4]   : 4'h0;
  assign s_addr  = busy ? m_addr[{idx_q, 5'b00000} +: 32]  : 32'h0;
  assign s_wdata = busy ? m_wdata[{idx_q, 5'b00000} +: 32] : 32'h0;

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Directed bench for gpio_bus_arbiter with a registered-ready GPIO slave.
// Slave model: ready <= valid, so a stale ready follows every access.

module tb_gpio_bus_arbiter;

  localparam int N = 2;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            resetn;
  logic [N-1:0]    m_valid;
  logic [N-1:0]    m_ready;
  logic [4*N-1:0]  m_wstrb;
  logic [32*N-1:0] m_addr;
  logic [32*N-1:0] m_wdata;
  logic [31:0]     m_rdata;
  logic            s_valid;
  logic            s_ready;
  logic [3:0]      s_wstrb;
  logic [31:0]     s_addr;
  logic [31:0]     s_wdata;
  logic [31:0]     s_rdata;
  logic [N-1:0]    grant;
`ifdef ARB_TIMEOUT_EN
  logic            timeout;
`endif

  logic        nordy = 1'b0;
  logic [31:0] io_out = 32'h0;
  int          wr_cnt = 0;
  int          vecs = 0;
  int          errs = 0;

  always #5 clk = ~clk;

  gpio_bus_arbiter #(
    .NUM_MASTERS   (N),
    .TIMEOUT_CYCLES(TO),
    .ERR_RDATA     (32'hFFFF_FFFF)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_wstrb(m_wstrb),
    .m_addr (m_addr),
    .m_wdata(m_wdata),
    .m_rdata(m_rdata),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_wstrb(s_wstrb),
    .s_addr (s_addr),
    .s_wdata(s_wdata),
    .s_rdata(s_rdata),
`ifdef ARB_TIMEOUT_EN
    .timeout(timeout),
`endif
    .grant  (grant)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) s_ready <= 1'b0;
    else         s_ready <= s_valid & ~nordy;
  end

  assign s_rdata = 32'hA500_0000 | s_addr;

  always @(posedge clk) begin
    if (s_valid && s_ready && (|s_wstrb)) begin
      wr_cnt <= wr_cnt + 1;
      if (s_addr == 32'h4)
        for (int b = 0; b < 4; b++)
          if (s_wstrb[b]) io_out[8*b +: 8] <= s_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  int pulses;
  int c0;
  int c1;

  initial begin
    resetn  = 1'b0;
    m_valid = '0;
    m_wstrb = '0;
    m_addr  = '0;
    m_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_svalid", 32'(s_valid), 0);
    chk("rst_mready", 32'(m_ready), 0);
    chk("rst_swstrb", 32'(s_wstrb), 0);
    chk("rst_saddr", s_addr, 0);
    resetn = 1'b1;

    // Single write by master 0
    @(negedge clk);
    m_valid       = 2'b01;
    m_addr[31:0]  = 32'h4;
    m_wdata[31:0] = 32'h1;
    m_wstrb[3:0]  = 4'h1;
    chk("w_pre_svalid", 32'(s_valid), 0);
    @(negedge clk);
    chk("w_grant", 32'(grant), 1);
    chk("w_svalid", 32'(s_valid), 1);
    chk("w_saddr", s_addr, 32'h4);
    chk("w_swdata", s_wdata, 32'h1);
    chk("w_swstrb", 32'(s_wstrb), 1);
    chk("w_mready0", 32'(m_ready), 0);
    @(negedge clk);
    chk("w_mready1", 32'(m_ready), 1);
    m_valid = '0;
    @(negedge clk);
    chk("w_rel_svalid", 32'(s_valid), 0);
    chk("w_rel_mready", 32'(m_ready), 0);
    chk("w_rel_swstrb", 32'(s_wstrb), 0);
    chk("w_rel_grant", 32'(grant), 0);
    chk("w_io_out", io_out, 32'h1);
    chk("w_wrcnt", 32'(wr_cnt), 1);
    @(negedge clk);
    chk("stale_mready", 32'(m_ready), 0);
    chk("stale_wrcnt", 32'(wr_cnt), 1);

    // Reset in the middle of a BUSY access by master 1
    m_valid        = 2'b10;
    m_addr[63:32]  = 32'h8;
    m_wstrb[7:4]   = 4'h0;
    @(negedge clk);
    chk("mid_grant", 32'(grant), 2);
    chk("mid_svalid", 32'(s_valid), 1);
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_svalid", 32'(s_valid), 0);
    chk("mid_rst_grant", 32'(grant), 0);
    chk("mid_rst_mready", 32'(m_ready), 0);

    // Contention: both read 0x08, master 0 must win after reset
    @(negedge clk);
    resetn        = 1'b1;
    m_valid       = 2'b11;
    m_addr[31:0]  = 32'h8;
    m_wstrb[3:0]  = 4'h0;
    @(negedge clk);
    chk("c_grant0", 32'(grant), 1);
    chk("c_saddr", s_addr, 32'h8);
    chk("c_mready_a", 32'(m_ready), 0);
    @(negedge clk);
    chk("c_mready0", 32'(m_ready), 1);
    chk("c_rdata0", m_rdata, 32'hA500_0008);
    m_valid = 2'b10;
    @(negedge clk);
    chk("c_rel_grant", 32'(grant), 0);
    chk("c_rel_mready", 32'(m_ready), 0);
    chk("c_rel_svalid", 32'(s_valid), 0);
    @(negedge clk);
    chk("c_grant1", 32'(grant), 2);
    chk("c_mready_b", 32'(m_ready), 0);
    @(negedge clk);
    chk("c_mready1", 32'(m_ready), 2);
    chk("c_rdata1", m_rdata, 32'hA500_0008);
    m_valid = '0;
    repeat (3) @(negedge clk);
    chk("c_idle_grant", 32'(grant), 0);

    // Fairness: both masters request continuously for 20 accesses
    m_valid = 2'b11;
    pulses  = 0;
    c0      = 0;
    c1      = 0;
    for (int cyc = 0; cyc < 100 && pulses < 20; cyc++) begin
      @(negedge clk);
      chk("f_onehot", 32'($countones(grant) <= 1), 1);
      if (m_ready != '0) begin
        chk("f_order", 32'(m_ready), (pulses % 2 == 0) ? 1 : 2);
        if (m_ready[0]) c0++;
        if (m_ready[1]) c1++;
        pulses++;
      end
    end
    chk("f_pulses", 32'(pulses), 20);
    chk("f_cnt0", 32'(c0), 10);
    chk("f_cnt1", 32'(c1), 10);
    m_valid = '0;
    repeat (3) @(negedge clk);

`ifdef ARB_TIMEOUT_EN
    // Slave never ready: watchdog completes on the 8th BUSY cycle
    nordy   = 1'b1;
    m_valid = 2'b01;
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      if (k < TO) begin
        chk("to_wait_mready", 32'(m_ready), 0);
        chk("to_wait_flag", 32'(timeout), 0);
      end else begin
        chk("to_mready", 32'(m_ready), 1);
        chk("to_flag", 32'(timeout), 1);
        chk("to_rdata", m_rdata, 32'hFFFF_FFFF);
      end
    end
    m_valid = 2'b10;
    nordy   = 1'b0;
    @(negedge clk);
    chk("to_rel_flag", 32'(timeout), 0);
    chk("to_rel_svalid", 32'(s_valid), 0);
    @(negedge clk);
    chk("to_next_grant", 32'(grant), 2);
    @(negedge clk);
    chk("to_next_mready", 32'(m_ready), 2);
    chk("to_next_flag", 32'(timeout), 0);
    m_valid = '0;
`else
    // Slave never ready: arbiter waits in BUSY
    nordy   = 1'b1;
    m_valid = 2'b01;
    repeat (20) @(negedge clk);
    chk("hang_grant", 32'(grant), 1);
    chk("hang_mready", 32'(m_ready), 0);
    chk("hang_svalid", 32'(s_valid), 1);
    resetn  = 1'b0;
    m_valid = '0;
    nordy   = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
`endif
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
